// File: rtl/adc_sport_pkg.sv
// adc_sport_pkg
//   Shared definitions for the ADC serial-port receiver:
//   - sport_state_e : receive FSM states (IDLE waiting for a frame sync,
//                     SHIFT collecting bits of a word)
//   - FS_PER_WORD / FS_PER_FRAME : frame-sync mode selectors
//   - ch_w()        : width of the channel index, never less than 1 bit
package adc_sport_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } sport_state_e;

  localparam int FS_PER_WORD  = 0;
  localparam int FS_PER_FRAME = 1;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adc_sport_fifo.sv
// sport_fifo
//   Synchronous single-clock FIFO holding received words.
//   clk_i, rst_l_i     : clock, asynchronous active-low reset
//   wr_en_i, wr_data_i : push request and data; accepted when not full,
//                        or when full and a pop happens in the same cycle
//   rd_en_i            : pop request (ignored when empty)
//   rd_data_o          : head entry (valid only when !empty_o)
//   full_o, empty_o    : occupancy flags
//   level_o            : number of stored entries, 0..DEPTH
//   DEPTH must be a power of two so the pointers wrap naturally.
module sport_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_l_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             wr_ok, rd_ok;

  assign full_o    = (level_q == LW'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign rd_ok = rd_en_i && !empty_o;
  assign wr_ok = wr_en_i && (!full_o || rd_ok);

  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_l_i) begin
    if (!rst_l_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/adc_sport_rx.sv
// adc_sport_rx
//   Receiver for a converter serial port (SCLK / SDOFS / SDO). Words arrive
//   MSB first, framed by SDOFS, and are tagged with a channel index before
//   being queued in an output FIFO.
//   adc_clk, rst_l      : block clock, asynchronous active-low reset
//   en                  : receive enable (se mirrors it one cycle later)
//   sync                : one-cycle frame restart (channel counter to 0)
//   sclk, sdofs, sdo    : serial port pins, asynchronous to adc_clk
//   se                  : serial enable to the converter
//   m_valid/m_ready     : output stream handshake
//   m_data, m_ch        : received word and its channel index
//   overflow, frame_err : sticky status, cleared by clr_status
//   fifo_level          : current FIFO occupancy
//   adc_clk must run at least 4x sclk so every sclk phase is seen.
module adc_sport_rx
  import adc_sport_pkg::*;
#(
  parameter int WORD_W     = 16,
  parameter int N_CH       = 6,
  parameter int FS_MODE    = FS_PER_WORD,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        adc_clk,
  input  logic                        rst_l,
  input  logic                        en,
  input  logic                        sync,
  input  logic                        sclk,
  input  logic                        sdofs,
  input  logic                        sdo,
  output logic                        se,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [WORD_W-1:0]           m_data,
  output logic [ch_w(N_CH)-1:0]       m_ch,
  output logic                        overflow,
  output logic                        frame_err,
  input  logic                        clr_status,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int CH_W  = ch_w(N_CH);
  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam int FW    = CH_W + WORD_W;

  // Pin synchronizers; sclk gets a third flop as edge-detect history.
  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic sdofs_s1_q, sdofs_s2_q;
  logic sdo_s1_q, sdo_s2_q;
  logic strobe;

  always_ff @(posedge adc_clk or negedge rst_l) begin
    if (!rst_l) begin
      sclk_s1_q  <= 1'b0;
      sclk_s2_q  <= 1'b0;
      sclk_s3_q  <= 1'b0;
      sdofs_s1_q <= 1'b0;
      sdofs_s2_q <= 1'b0;
      sdo_s1_q   <= 1'b0;
      sdo_s2_q   <= 1'b0;
    end else begin
      sclk_s1_q  <= sclk;
      sclk_s2_q  <= sclk_s1_q;
      sclk_s3_q  <= sclk_s2_q;
      sdofs_s1_q <= sdofs;
      sdofs_s2_q <= sdofs_s1_q;
      sdo_s1_q   <= sdo;
      sdo_s2_q   <= sdo_s1_q;
    end
  end

  // sdofs/sdo pass through the same depth as sclk, so at the strobe they
  // show the values present at the pin rising edge.
  assign strobe = sclk_s2_q && !sclk_s3_q;

  // Receive FSM
  sport_state_e       state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0]  shreg_q, shreg_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [WORD_W-1:0]  shifted;
  logic [WORD_W-1:0]  restart;
  logic [CH_W-1:0]    ch_next;
  logic               last_ch;
  logic               push;
  logic               fe_set;
  logic               se_q;

  assign shifted = {shreg_q[WORD_W-2:0], sdo_s2_q};
  assign restart = {{(WORD_W-1){1'b0}}, sdo_s2_q};
  assign last_ch = (ch_q == CH_W'(N_CH - 1));
  assign ch_next = last_ch ? '0 : ch_q + CH_W'(1);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    ch_d      = ch_q;
    push      = 1'b0;
    fe_set    = 1'b0;

    if (!en) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
    end else if (sync) begin
      // sync beats a completing word: nothing is pushed this cycle.
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      ch_d      = '0;
    end else if (strobe) begin
      case (state_q)
        ST_IDLE: begin
          if (sdofs_s2_q) begin
            state_d   = ST_SHIFT;
            shreg_d   = restart;
            bit_cnt_d = CNT_W'(1);
            // In per-frame mode a frame sync always opens channel 0.
            if (FS_MODE == FS_PER_FRAME && ch_q != '0) begin
              fe_set = 1'b1;
              ch_d   = '0;
            end
          end
        end
        ST_SHIFT: begin
          if (sdofs_s2_q) begin
            // Unexpected frame sync: drop the partial word, restart on this bit.
            fe_set    = 1'b1;
            shreg_d   = restart;
            bit_cnt_d = CNT_W'(1);
            if (FS_MODE == FS_PER_FRAME) ch_d = '0;
          end else if (bit_cnt_q == CNT_W'(WORD_W - 1)) begin
            push      = 1'b1;
            shreg_d   = shifted;
            bit_cnt_d = '0;
            ch_d      = ch_next;
            if (FS_MODE == FS_PER_WORD || last_ch) state_d = ST_IDLE;
          end else begin
            shreg_d   = shifted;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge adc_clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      ch_q      <= '0;
      se_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      ch_q      <= ch_d;
      se_q      <= en;
    end
  end

  assign se = se_q;

  // Output queue
  logic [FW-1:0] rd_data;
  logic          fifo_full, fifo_empty, pop;

  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;

  sport_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (adc_clk),
    .rst_l_i   (rst_l),
    .wr_en_i   (push),
    .wr_data_i ({ch_q, shifted}),
    .rd_en_i   (pop),
    .rd_data_o (rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  // Stored entries are not reset, so the outputs read zero while empty.
  assign m_data = m_valid ? rd_data[WORD_W-1:0] : '0;
  assign m_ch   = m_valid ? rd_data[FW-1:WORD_W] : '0;

  // Sticky status; a set event in the same cycle as clr_status wins.
  logic ovf_q, fe_q;
  logic ovf_set;

  assign ovf_set = push && fifo_full && !pop;

  always_ff @(posedge adc_clk or negedge rst_l) begin
    if (!rst_l) begin
      ovf_q <= 1'b0;
      fe_q  <= 1'b0;
    end else begin
      ovf_q <= ovf_set || (ovf_q && !clr_status);
      fe_q  <= fe_set  || (fe_q  && !clr_status);
    end
  end

  assign overflow  = ovf_q;
  assign frame_err = fe_q;

endmodule
